// File: rtl/apb_ram_slave_pkg.sv
// apb_ram_slave_pkg: shared FSM state type, lane/counter sizes and error-cause bit positions
package apb_ram_slave_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;
  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam int ERR_RANGE = 0;
  localparam int ERR_ALIGN = 1;
  localparam int ERR_RSTRB = 2;
  localparam int ERR_PROT = 3;
  localparam int ERR_N = 4;
endpackage

// File: rtl/apb_ram_slave_if.sv
// apb_ram_slave_if: APB4 bus bundle (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT out of master, PRDATA/PREADY/PSLVERR back)
interface apb_ram_slave_if #(parameter int ADDR_WIDTH = 32);
  logic PSEL;
  logic PENABLE;
  logic PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0] PSTRB;
  logic [2:0] PPROT;
  logic [31:0] PRDATA;
  logic PREADY;
  logic PSLVERR;
  modport master(output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, input PRDATA, PREADY, PSLVERR);
  modport slave(input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_ram_slave_mem.sv
// apb_ram_slave_mem: single-port byte-enabled word RAM; ports clk, rst (clears read reg), we/be/addr/wdata write, re loads rdata, clr zeroes rdata
module apb_ram_slave_mem import apb_ram_slave_pkg::*; #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic             clr,
  input  logic [LANES-1:0] be,
  input  logic [AW-1:0]    addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < LANES; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk)
    if (rst || clr) rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

// File: rtl/apb_ram_slave.sv
// apb_ram_slave: APB4 completer over a byte-strobed RAM with WAIT_CYCLES wait states and PSLVERR on illegal access.
// Ports: PCLK, PRESET (sync active-high), bus (apb_ram_slave_if.slave). Macro APB_PROT_CHECK_EN adds the non-secure upper-half error.
module apb_ram_slave import apb_ram_slave_pkg::*; #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 0
) (
  input logic PCLK,
  input logic PRESET,
  apb_ram_slave_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int IW = ADDR_WIDTH - 2;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0] idx_q;
  logic wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [LANES-1:0] strb_q;
  logic [2:0] prot_q;
  logic err_q;
  logic [IW-1:0] idx;
  logic [ERR_N-1:0] err;
  logic setup, wr_cur, err_cur, enter_ready, we, re, clr;
  logic [AW-1:0] addr;
  logic [31:0] rdata;
  logic unused_prot;
  assign unused_prot = ^prot_q;
  assign idx = bus.PADDR[ADDR_WIDTH-1:2];
  assign setup = bus.PSEL & ~bus.PENABLE;
  always_comb begin
    err[ERR_RANGE] = idx >= IW'(MEM_DEPTH);
    err[ERR_ALIGN] = |bus.PADDR[1:0];
    err[ERR_RSTRB] = ~bus.PWRITE & |bus.PSTRB;
`ifdef APB_PROT_CHECK_EN
    err[ERR_PROT] = bus.PPROT[1] & (idx >= IW'(MEM_DEPTH / 2));
`else
    err[ERR_PROT] = 1'b0;
`endif
  end
  always_ff @(posedge PCLK) state <= PRESET ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (setup ? (WAIT_CYCLES == 0 ? READY : WAIT) : IDLE) :
          !bus.PSEL     ? IDLE :
          state == WAIT ? (cnt == '0 ? READY : WAIT) :
          bus.PENABLE   ? IDLE : READY;
  always_ff @(posedge PCLK) begin
    if (PRESET) cnt <= '0;
    else if (state == IDLE && setup) begin
      cnt <= WAIT_CYCLES == 0 ? '0 : CNT_W'(WAIT_CYCLES - 1);
      idx_q <= idx[AW-1:0];
      wr_q <= bus.PWRITE;
      wdata_q <= bus.PWDATA;
      strb_q <= bus.PSTRB;
      prot_q <= bus.PPROT;
      err_q <= |err;
    end
    else if (state == WAIT) cnt <= cnt - 1'b1;
  end
  // With zero wait states READY is entered straight from IDLE, so the read uses the live bus, not the latched request.
  always_comb begin
    wr_cur = state == IDLE ? bus.PWRITE : wr_q;
    err_cur = state == IDLE ? |err : err_q;
    enter_ready = nxt == READY && state != READY;
    re = enter_ready & ~wr_cur & ~err_cur;
    clr = enter_ready & ~wr_cur & err_cur;
    we = state == READY & bus.PSEL & bus.PENABLE & wr_q & ~err_q & ~PRESET;
    addr = state == IDLE ? idx[AW-1:0] : idx_q;
    bus.PREADY = state == READY;
    bus.PSLVERR = state == READY & err_q;
    bus.PRDATA = rdata;
  end
  apb_ram_slave_mem #(.DEPTH(MEM_DEPTH)) u_mem (
    .clk(PCLK),
    .rst(PRESET),
    .we(we),
    .re(re),
    .clr(clr),
    .be(strb_q),
    .addr(addr),
    .wdata(wdata_q[31:0]),
    .rdata(rdata)
  );
endmodule
